// File: rtl/top.sv
// Local-alignment (Smith-Waterman / Gotoh affine gap) scorer.
// The S query is fed in chunks of PE_Array_size bases. Each chunk occupies the
// PE rows of one pass. T is stored in an on-chip buffer and streamed one base
// per cycle. For each T column, the whole PE column settles combinationally:
// F and H ripple from PE 0 down to the last PE. The last valid PE's H/F is
// written back beside each T base, and the next pass uses it as its upper
// boundary.
module top #(
  parameter int PE_Array_size     = 16,
  parameter int PE_Array_size_log = 4,
  parameter int V_E_F_Bit         = 8,
  parameter int Sram_Addr         = 1024
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_set_t,
  input  logic [17:0]                  i_t,
  input  logic                         i_start_cal,
  output logic                         o_busy,
  output logic                         o_request_s,
  input  logic [2*PE_Array_size-1:0]   i_s,
  input  logic [PE_Array_size_log:0]   i_s_valid,
  input  logic [3:0]                   i_match,
  input  logic [3:0]                   i_mismatch,
  input  logic [7:0]                   i_minusAlpha,
  input  logic [7:0]                   i_minusBeta,
  input  logic                         i_param_valid,
  output logic [V_E_F_Bit-1:0]         o_result,
  output logic                         o_valid
);

  localparam int PE = PE_Array_size;
  localparam int W  = V_E_F_Bit;
  localparam int VW = PE_Array_size_log + 1;
  localparam int AW = (Sram_Addr > 1) ? $clog2(Sram_Addr) : 1;
  localparam int LW = $clog2(Sram_Addr + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_RUN} state_t;

  function automatic logic [W-1:0] sat_sub(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [3:0] b);
    logic [W:0] s;
    s = {1'b0, a} + (W+1)'(b);
    return s[W] ? '1 : s[W-1:0];
  endfunction

  function automatic logic [W-1:0] max2(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Control and datapath state
  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                req_q, req_d;
  logic                valid_q, valid_d;
  logic [W-1:0]        result_q, result_d;
  logic [W-1:0]        best_q, best_d;
  logic [3:0]          match_q, match_d;
  logic [3:0]          mismatch_q, mismatch_d;
  logic [7:0]          alpha_q, alpha_d;
  logic [7:0]          beta_q, beta_d;
  logic [LW-1:0]       t_len_q, t_len_d;
  logic [LW-1:0]       col_q, col_d;
  logic                set_t_prev_q, set_t_prev_d;
  logic                first_pass_q, first_pass_d;
  logic [2*PE-1:0]     s_bases_q, s_bases_d;
  logic [VW-1:0]       s_valid_q, s_valid_d;
  logic [W-1:0]        bnd_diag_q, bnd_diag_d;
  logic [W-1:0]        h_prev_q [PE];
  logic [W-1:0]        h_prev_d [PE];
  logic [W-1:0]        e_prev_q [PE];
  logic [W-1:0]        e_prev_d [PE];

  // T buffer: {base[1:0], boundary H, boundary F}
  logic [17:0]         t_mem [Sram_Addr];
  logic                mem_we;
  logic [AW-1:0]       mem_waddr;
  logic [17:0]         mem_wdata;
  logic [17:0]         rd_word;

  // Column datapath results
  logic [1:0]          t_base;
  logic [W-1:0]        bnd_h, bnd_f;
  logic [W-1:0]        h_new [PE];
  logic [W-1:0]        e_new [PE];
  logic [W-1:0]        f_new [PE];
  logic [W-1:0]        h_last, f_last;
  logic [W-1:0]        best_col;
  logic                pass_end, pass_full;

  assign rd_word = t_mem[col_q[AW-1:0]];
  assign t_base  = rd_word[17:16];
  assign bnd_h   = first_pass_q ? '0 : rd_word[15:8];
  assign bnd_f   = first_pass_q ? '0 : rd_word[7:0];

  // One T column through the PE chain: F/H ripple down, E uses each row's previous column
  always_comb begin : pe_column
    logic [W-1:0] up_h, up_f, diag, score;
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    up_h     = bnd_h;
    up_f     = bnd_f;
    diag     = bnd_diag_q;
    score    = '0;
    h_last   = '0;
    f_last   = '0;
    best_col = '0;
    for (int k = 0; k < PE; k++) begin
      e_new[k] = max2(sat_sub(h_prev_q[k], alpha_q), sat_sub(e_prev_q[k], beta_q));
      f_new[k] = max2(sat_sub(up_h, alpha_q), sat_sub(up_f, beta_q));
      score    = (s_bases_q[2*k +: 2] == t_base) ? sat_add(diag, match_q)
                                                 : sat_sub(diag, W'(mismatch_q));
      h_new[k] = max2(score, max2(e_new[k], f_new[k]));
      if (VW'(k) < s_valid_q) best_col = max2(best_col, h_new[k]);
      if (VW'(k + 1) == s_valid_q) begin
        h_last = h_new[k];
        f_last = f_new[k];
      end
      diag = h_prev_q[k];
      up_h = h_new[k];
      up_f = f_new[k];
    end
  end

  // Next-state logic: parameter/T loading, pass sequencing and result hand-off
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    req_d        = 1'b0;
    valid_d      = 1'b0;
    result_d     = result_q;
    best_d       = best_q;
    match_d      = match_q;
    mismatch_d   = mismatch_q;
    alpha_d      = alpha_q;
    beta_d       = beta_q;
    t_len_d      = t_len_q;
    col_d        = col_q;
    set_t_prev_d = i_set_t;
    first_pass_d = first_pass_q;
    s_bases_d    = s_bases_q;
    s_valid_d    = s_valid_q;
    bnd_diag_d   = bnd_diag_q;
    h_prev_d     = h_prev_q;
    e_prev_d     = e_prev_q;
    mem_we       = 1'b0;
    mem_waddr    = '0;
    mem_wdata    = '0;
    pass_end     = 1'b0;
    pass_full    = 1'b0;

    if (i_param_valid && !busy_q) begin
      match_d    = i_match;
      mismatch_d = i_mismatch;
      alpha_d    = i_minusAlpha;
      beta_d     = i_minusBeta;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (i_set_t) begin
          mem_wdata = {i_t[17:16], 16'h0000};
          if (!set_t_prev_q) begin
            // A new burst restarts T at address 0.
            mem_we  = 1'b1;
            t_len_d = LW'(1);
          end else if (t_len_q < LW'(Sram_Addr)) begin
            mem_we    = 1'b1;
            mem_waddr = t_len_q[AW-1:0];
            t_len_d   = t_len_q + 1'b1;
          end
        end
        if (i_start_cal) begin
          state_d      = ST_REQ;
          busy_d       = 1'b1;
          req_d        = 1'b1;
          best_d       = '0;
          first_pass_d = 1'b1;
        end
      end
      ST_REQ: begin
        s_bases_d  = i_s;
        s_valid_d  = i_s_valid;
        col_d      = '0;
        bnd_diag_d = '0;
        for (int k = 0; k < PE; k++) begin
          h_prev_d[k] = '0;
          e_prev_d[k] = '0;
        end
        if (i_s_valid == '0 || t_len_q == '0) begin
          pass_end  = 1'b1;
          pass_full = (i_s_valid == VW'(PE));
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        h_prev_d   = h_new;
        e_prev_d   = e_new;
        bnd_diag_d = bnd_h;
        best_d     = max2(best_q, best_col);
        mem_we     = 1'b1;
        mem_waddr  = col_q[AW-1:0];
        mem_wdata  = {t_base, h_last, f_last};
        col_d      = col_q + 1'b1;
        if (col_q == t_len_q - 1'b1) begin
          pass_end  = 1'b1;
          pass_full = (s_valid_q == VW'(PE));
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A full chunk chains another pass; anything shorter finishes the query.
    if (pass_end) begin
      if (pass_full) begin
        state_d      = ST_REQ;
        req_d        = 1'b1;
        first_pass_d = 1'b0;
      end else begin
        state_d  = ST_IDLE;
        busy_d   = 1'b0;
        valid_d  = 1'b1;
        result_d = best_d;
      end
    end
  end

  // T buffer write port
  // NOTE: storage arrays carry no reset; the T length and first-pass flag decide what is valid.
  always_ff @(posedge clk) begin
    if (mem_we) t_mem[mem_waddr] <= mem_wdata;
  end

  // State registers, synchronous active-high reset on rst_n
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst_n) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      req_q        <= 1'b0;
      valid_q      <= 1'b0;
      result_q     <= '0;
      best_q       <= '0;
      match_q      <= '0;
      mismatch_q   <= '0;
      alpha_q      <= '0;
      beta_q       <= '0;
      t_len_q      <= '0;
      col_q        <= '0;
      set_t_prev_q <= 1'b0;
      first_pass_q <= 1'b1;
      s_bases_q    <= '0;
      s_valid_q    <= '0;
      bnd_diag_q   <= '0;
      for (int k = 0; k < PE; k++) begin
        h_prev_q[k] <= '0;
        e_prev_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      req_q        <= req_d;
      valid_q      <= valid_d;
      result_q     <= result_d;
      best_q       <= best_d;
      match_q      <= match_d;
      mismatch_q   <= mismatch_d;
      alpha_q      <= alpha_d;
      beta_q       <= beta_d;
      t_len_q      <= t_len_d;
      col_q        <= col_d;
      set_t_prev_q <= set_t_prev_d;
      first_pass_q <= first_pass_d;
      s_bases_q    <= s_bases_d;
      s_valid_q    <= s_valid_d;
      bnd_diag_q   <= bnd_diag_d;
      h_prev_q     <= h_prev_d;
      e_prev_q     <= e_prev_d;
    end
  end

  assign o_busy      = busy_q;
  assign o_request_s = req_q;
  assign o_valid     = valid_q;
  assign o_result    = result_q;

endmodule

// File: tb/tb_top.sv
// Self-checking bench for the local-alignment scorer. Expected scores come from
// a plain full-matrix Gotoh model over the whole S x T grid.
module tb_top;
  localparam int PE = 16;
  localparam int PL = 4;

  typedef int iq_t[$];

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_set_t;
  logic [17:0]     i_t;
  logic            i_start_cal;
  logic            o_busy;
  logic            o_request_s;
  logic [2*PE-1:0] i_s;
  logic [PL:0]     i_s_valid;
  logic [3:0]      i_match, i_mismatch;
  logic [7:0]      i_minusAlpha, i_minusBeta;
  logic            i_param_valid;
  logic [7:0]      o_result;
  logic            o_valid;

  int   errors = 0;
  int   checks = 0;
  iq_t  cur_t;
  int   cur_ma = 0, cur_mm = 0, cur_al = 0, cur_be = 0;

  always #5 clk = ~clk;

  top #(.PE_Array_size(PE), .PE_Array_size_log(PL), .V_E_F_Bit(8), .Sram_Addr(1024)) dut (
    .clk(clk), .rst_n(rst_n), .i_set_t(i_set_t), .i_t(i_t), .i_start_cal(i_start_cal),
    .o_busy(o_busy), .o_request_s(o_request_s), .i_s(i_s), .i_s_valid(i_s_valid),
    .i_match(i_match), .i_mismatch(i_mismatch), .i_minusAlpha(i_minusAlpha),
    .i_minusBeta(i_minusBeta), .i_param_valid(i_param_valid), .o_result(o_result),
    .o_valid(o_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic iq_t seq(input string s);
    iq_t q;
    for (int i = 0; i < s.len(); i++) begin
      case (s[i])
        "A": q.push_back(0);
        "C": q.push_back(1);
        "G": q.push_back(2);
        default: q.push_back(3);
      endcase
    end
    return q;
  endfunction

  function automatic iq_t rep(input int b, input int n);
    iq_t q;
    for (int i = 0; i < n; i++) q.push_back(b);
    return q;
  endfunction

  function automatic iq_t rnd(input int n);
    iq_t q;
    for (int i = 0; i < n; i++) q.push_back(int'($urandom_range(3, 0)));
    return q;
  endfunction

  function automatic int clamp(input int v);
    return (v < 0) ? 0 : ((v > 255) ? 255 : v);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Full-matrix Gotoh local alignment, row by row over S, every cell clamped to 0..255.
  function automatic int sw_ref(input iq_t t, input iq_t s, input int ma, input int mm,
                                input int al, input int be);
    int hp[], fp[], hn[], fn[];
    int best, e, f, h, hl, diag, sc;
    best = 0;
    hp = new[t.size()];
    fp = new[t.size()];
    hn = new[t.size()];
    fn = new[t.size()];
    foreach (hp[j]) begin hp[j] = 0; fp[j] = 0; end
    foreach (s[i]) begin
      e = 0; hl = 0; diag = 0;
      foreach (t[j]) begin
        e    = clamp(max2(hl - al, e - be));
        f    = clamp(max2(hp[j] - al, fp[j] - be));
        sc   = (s[i] == t[j]) ? clamp(diag + ma) : clamp(diag - mm);
        h    = max2(max2(0, sc), max2(e, f));
        diag = hp[j];
        hl   = h;
        hn[j] = h;
        fn[j] = f;
        best = max2(best, h);
      end
      foreach (hp[j]) begin hp[j] = hn[j]; fp[j] = fn[j]; end
    end
    return best;
  endfunction

  task automatic set_params(input int ma, input int mm, input int al, input int be);
    i_match = 4'(ma); i_mismatch = 4'(mm); i_minusAlpha = 8'(al); i_minusBeta = 8'(be);
    i_param_valid = 1'b1;
    @(posedge clk); #1;
    i_param_valid = 1'b0;
    cur_ma = ma; cur_mm = mm; cur_al = al; cur_be = be;
  endtask

  task automatic load_t(input iq_t t);
    i_set_t = 1'b0;
    @(posedge clk); #1;
    foreach (t[i]) begin
      i_set_t = 1'b1;
      i_t     = {2'(t[i]), 16'($urandom)};
      @(posedge clk); #1;
    end
    i_set_t = 1'b0;
    cur_t = t;
  endtask

  // Starts a query, serves every chunk request from s, checks score, pulse counts and hold.
  task automatic run_query(input string tag, input iq_t s, input bit poke_param);
    int req_cnt, idx, cyc, cnt, exp, exp_req;
    bit done;
    logic [7:0] res;
    logic [2*PE-1:0] chunk;
    logic [3:0] old_match;
    exp     = sw_ref(cur_t, s, cur_ma, cur_mm, cur_al, cur_be);
    exp_req = s.size() / PE + 1;
    req_cnt = 0; idx = 0; cyc = 0; done = 1'b0; res = '0;
    old_match = i_match;
    i_start_cal = 1'b1;
    @(posedge clk); #1;
    i_start_cal = 1'b0;
    check({tag, "_busy_rise"}, 32'(o_busy), 32'd1);
    if (poke_param) begin
      i_match = 4'd7;
      i_param_valid = 1'b1;
    end
    while (!done && cyc < 5000) begin
      if (o_request_s) begin
        req_cnt++;
        cnt = (s.size() - idx > PE) ? PE : s.size() - idx;
        chunk = '0;
        for (int j = 0; j < cnt; j++) chunk[2*j +: 2] = 2'(s[idx + j]);
        i_s = chunk;
        i_s_valid = (PL+1)'(cnt);
        idx += cnt;
      end
      @(posedge clk); #1;
      cyc++;
      i_param_valid = 1'b0;
      i_match = old_match;
      if (o_valid) begin
        done = 1'b1;
        res  = o_result;
        check({tag, "_busy_fall"}, 32'(o_busy), 32'd0);
      end
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_result"}, 32'(res), 32'(exp));
    check({tag, "_requests"}, 32'(req_cnt), 32'(exp_req));
    @(posedge clk); #1;
    check({tag, "_valid_pulse"}, 32'(o_valid), 32'd0);
    check({tag, "_hold"}, 32'(o_result), 32'(exp));
  endtask

  initial begin
    iq_t tq, sq;
    rst_n = 1'b1; i_set_t = 1'b0; i_t = '0; i_start_cal = 1'b0; i_s = '0; i_s_valid = '0;
    i_match = '0; i_mismatch = '0; i_minusAlpha = '0; i_minusBeta = '0; i_param_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_req", 32'(o_request_s), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_result", 32'(o_result), 32'd0);
    rst_n = 1'b0;

    // Directed cases with match=2 mismatch=1 alpha=2 beta=1
    set_params(2, 1, 2, 1);
    load_t(seq("ACGT"));
    run_query("acgt_acgt", seq("ACGT"), 1'b0);
    run_query("acgt_tttt", seq("TTTT"), 1'b0);
    load_t(seq("ACGGT"));
    run_query("gap_in_s", seq("ACGT"), 1'b0);
    load_t(rep(0, 20));
    run_query("two_pass", rep(0, 17), 1'b0);
    run_query("param_busy", rep(0, 17), 1'b1);
    run_query("param_after", rep(0, 17), 1'b0);
    run_query("s_len16", rep(0, 16), 1'b0);
    run_query("s_len0", rep(0, 0), 1'b0);

    // Saturation at 255
    set_params(15, 3, 4, 2);
    load_t(rep(0, 40));
    run_query("saturate", rep(0, 40), 1'b0);

    // Randomized queries against the model
    for (int it = 0; it < 8; it++) begin
      set_params(int'($urandom_range(15, 0)), int'($urandom_range(15, 0)),
                 int'($urandom_range(10, 0)), int'($urandom_range(5, 0)));
      tq = rnd(int'($urandom_range(40, 1)));
      sq = rnd(int'($urandom_range(40, 0)));
      if (it % 2 == 0) begin
        tq = rep(int'($urandom_range(3, 0)), 10);
        tq = {tq, rnd(int'($urandom_range(20, 1)))};
        sq = {tq[0:9], rnd(int'($urandom_range(30, 0)))};
      end
      load_t(tq);
      run_query($sformatf("rand%0d", it), sq, 1'b0);
    end

    // Reset in the middle of a query
    set_params(2, 1, 2, 1);
    load_t(rep(0, 20));
    i_start_cal = 1'b1;
    @(posedge clk); #1;
    i_start_cal = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (o_request_s) begin i_s = '0; i_s_valid = (PL+1)'(PE); end
      @(posedge clk); #1;
    end
    check("midrst_busy_before", 32'(o_busy), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    check("midrst_busy", 32'(o_busy), 32'd0);
    check("midrst_req", 32'(o_request_s), 32'd0);
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_result", 32'(o_result), 32'd0);
    cur_t = {};
    cur_ma = 0; cur_mm = 0; cur_al = 0; cur_be = 0;
    run_query("after_rst", seq("ACGT"), 1'b0);
    set_params(2, 1, 2, 1);
    run_query("after_rst_params", seq("AAAA"), 1'b0);
    load_t(seq("AAAA"));
    run_query("after_rst_reload", seq("AAAA"), 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
